// File: rtl/clamp_rgb_sequencer_if.sv
// Handshake and data bundle for clamp_rgb_sequencer.
// The slave modport is the sequencer side; master is the producer/consumer side.
interface clamp_rgb_sequencer_if #(
  parameter int INW  = 16,
  parameter int OUTW = 8
);
  logic                   i_inValid;
  logic                   o_inReady;
  logic signed [INW-1:0]  i_r;
  logic signed [INW-1:0]  i_g;
  logic signed [INW-1:0]  i_b;
  logic                   o_outValid;
  logic                   i_outReady;
  logic signed [OUTW-1:0] o_r;
  logic signed [OUTW-1:0] o_g;
  logic signed [OUTW-1:0] o_b;
  logic [2:0]             o_sat;
  logic                   i_clrCount;
  logic [15:0]            o_satCount;

  modport slave (
    input  i_inValid, i_r, i_g, i_b, i_outReady, i_clrCount,
    output o_inReady, o_outValid, o_r, o_g, o_b, o_sat, o_satCount
  );

  modport master (
    output i_inValid, i_r, i_g, i_b, i_outReady, i_clrCount,
    input  o_inReady, o_outValid, o_r, o_g, o_b, o_sat, o_satCount
  );
endinterface

// File: rtl/clamp_rgb_sequencer.sv
// Clamps an RGB triplet from signed INW to signed OUTW bits through one shared
// saturation unit, one channel per cycle, with a wrapping saturated-pixel counter.
module clamp_rgb_sequencer #(
  parameter int INW  = 16,
  parameter int OUTW = 8
) (
  input logic                    clk,
  input logic                    i_rst,
  clamp_rgb_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, S_R, S_G, S_B, OUT} state_e;

  localparam int MAXI = 2**(OUTW-1) - 1;
  localparam int MINI = -(2**(OUTW-1));
  localparam logic signed [INW-1:0] MAXV = INW'(MAXI);
  localparam logic signed [INW-1:0] MINV = INW'(MINI);

  state_e                 state_q, state_d;
  logic signed [INW-1:0]  hold_r_q, hold_g_q, hold_b_q;
  logic signed [OUTW-1:0] out_r_q, out_g_q, out_b_q;
  logic [2:0]             sat_q;
  logic [15:0]            cnt_q;

  logic                   in_ready, out_hs, accept;
  logic signed [INW-1:0]  clamp_x;
  logic signed [OUTW-1:0] clamp_y;
  logic                   clamp_hi, clamp_lo, clamp_sat;

  always_comb begin
    in_ready = (state_q == IDLE) | ((state_q == OUT) & bus.i_outReady);
    out_hs   = (state_q == OUT) & bus.i_outReady;
    accept   = in_ready & bus.i_inValid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = S_R;
      S_R:     state_d = S_G;
      S_G:     state_d = S_B;
      S_B:     state_d = OUT;
      OUT:     if (out_hs) state_d = bus.i_inValid ? S_R : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared saturation unit; the operand follows the channel being processed.
  always_comb begin
    case (state_q)
      S_R:     clamp_x = hold_r_q;
      S_G:     clamp_x = hold_g_q;
      default: clamp_x = hold_b_q;
    endcase
    clamp_hi  = clamp_x > MAXV;
    clamp_lo  = clamp_x < MINV;
    clamp_sat = clamp_hi | clamp_lo;
    if (clamp_hi)      clamp_y = MAXV[OUTW-1:0];
    else if (clamp_lo) clamp_y = MINV[OUTW-1:0];
    else               clamp_y = clamp_x[OUTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      hold_r_q <= '0;
      hold_g_q <= '0;
      hold_b_q <= '0;
      out_r_q  <= '0;
      out_g_q  <= '0;
      out_b_q  <= '0;
      sat_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_r_q <= bus.i_r;
        hold_g_q <= bus.i_g;
        hold_b_q <= bus.i_b;
      end
      case (state_q)
        S_R: begin out_r_q <= clamp_y; sat_q[0] <= clamp_sat; end
        S_G: begin out_g_q <= clamp_y; sat_q[1] <= clamp_sat; end
        S_B: begin out_b_q <= clamp_y; sat_q[2] <= clamp_sat; end
        default: ;
      endcase
      // Clear wins over a same-cycle increment.
      if (bus.i_clrCount)      cnt_q <= '0;
      else if (out_hs & |sat_q) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.o_inReady  = in_ready;
  assign bus.o_outValid = (state_q == OUT);
  assign bus.o_r        = out_r_q;
  assign bus.o_g        = out_g_q;
  assign bus.o_b        = out_b_q;
  assign bus.o_sat      = sat_q;
  assign bus.o_satCount = cnt_q;

endmodule

// File: tb/tb_clamp_rgb_sequencer.sv
// Self-checking bench for clamp_rgb_sequencer: directed vectors, multi-cycle
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_clamp_rgb_sequencer;
  localparam int INW  = 16;
  localparam int OUTW = 8;

  typedef struct {
    int r; int g; int b;
    logic [2:0] sat;
  } exp_t;

  typedef struct {
    int r; int g; int b;
    int er; int eg; int eb;
    logic [2:0] sat;
    int cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clamp_rgb_sequencer_if #(.INW(INW), .OUTW(OUTW)) bus ();
  clamp_rgb_sequencer #(.INW(INW), .OUTW(OUTW)) dut (.clk(clk), .i_rst(rst), .bus(bus));

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  int   model_cnt = 0;

  function automatic int clampv(input int x);
    int hi, lo;
    hi = (1 << (OUTW-1)) - 1;
    lo = -(1 << (OUTW-1));
    return (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic exp_t model(input int r, input int g, input int b);
    exp_t e;
    e.r = clampv(r); e.g = clampv(g); e.b = clampv(b);
    e.sat = {e.b != b, e.g != g, e.r != r};
    return e;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int r, input int g, input int b);
    bus.i_r = r[INW-1:0];
    bus.i_g = g[INW-1:0];
    bus.i_b = b[INW-1:0];
  endtask

  function automatic int rnd_ch();
    logic signed [15:0] t;
    int unsigned k;
    k = $urandom_range(0, 7);
    t = 16'($urandom);
    case (k)
      0: return 127;
      1: return 128;
      2: return -128;
      3: return -129;
      4: return int'(t) % 200;
      default: return int'(t);
    endcase
  endfunction

  // Scoreboard: sampled on the falling edge, predicts the effect of the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic hs_sat;
    if (rst) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      hs_sat = 1'b0;
      chk("satCount", bus.o_satCount, model_cnt);
      if (bus.o_outValid && bus.i_outReady) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got r=%0d with no triplet outstanding", bus.o_r);
        end else begin
          e = exp_q.pop_front();
          chk("mon_r", bus.o_r, e.r);
          chk("mon_g", bus.o_g, e.g);
          chk("mon_b", bus.o_b, e.b);
          chk("mon_sat", bus.o_sat, e.sat);
          hs_sat = |e.sat;
        end
      end
      if (bus.i_clrCount) model_cnt = 0;
      else if (hs_sat)    model_cnt = (model_cnt + 1) & 32'hFFFF;
      if (bus.o_inReady && bus.i_inValid)
        exp_q.push_back(model(int'(bus.i_r), int'(bus.i_g), int'(bus.i_b)));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_expect(input vec_t v, input string tag);
    drive(v.r, v.g, v.b);
    bus.i_inValid = 1'b1;
    chk({tag, "_inReady"}, bus.o_inReady, 1);
    step();
    bus.i_inValid = 1'b0;
    chk({tag, "_lat0"}, bus.o_outValid, 0);
    step();
    chk({tag, "_lat1"}, bus.o_outValid, 0);
    step();
    chk({tag, "_lat2"}, bus.o_outValid, 0);
    step();
    chk({tag, "_valid"}, bus.o_outValid, 1);
    chk({tag, "_r"}, bus.o_r, v.er);
    chk({tag, "_g"}, bus.o_g, v.eg);
    chk({tag, "_b"}, bus.o_b, v.eb);
    chk({tag, "_sat"}, bus.o_sat, v.sat);
    step();
    chk({tag, "_idle"}, bus.o_outValid, 0);
    chk({tag, "_cnt"}, bus.o_satCount, v.cnt);
  endtask

  initial begin
    vec_t tbl[4];
    vec_t sv;
    int   data_r[8], data_g[8], data_b[8];
    int   times[8];
    int   idx, nout;
    logic acc;
    exp_t ea;

    tbl[0] = '{r: 100,  g: -1,    b: 0,      er: 100,  eg: -1,   eb: 0,    sat: 3'b000, cnt: 0};
    tbl[1] = '{r: 127,  g: -128,  b: 128,    er: 127,  eg: -128, eb: 127,  sat: 3'b100, cnt: 1};
    tbl[2] = '{r: -129, g: 32767, b: -32768, er: -128, eg: 127,  eb: -128, sat: 3'b111, cnt: 2};
    tbl[3] = '{r: 0,    g: -200,  b: 300,    er: 0,    eg: -128, eb: 127,  sat: 3'b110, cnt: 3};
    sv     = '{r: 200,  g: 5,     b: -7,     er: 127,  eg: 5,    eb: -7,   sat: 3'b001, cnt: 0};

    rst = 1'b1;
    bus.i_inValid = 1'b0; bus.i_outReady = 1'b0; bus.i_clrCount = 1'b0;
    drive(0, 0, 0);
    step(); step();
    rst = 1'b0;
    chk("rst_outValid", bus.o_outValid, 0);
    chk("rst_inReady", bus.o_inReady, 1);
    chk("rst_r", bus.o_r, 0);
    chk("rst_g", bus.o_g, 0);
    chk("rst_b", bus.o_b, 0);
    chk("rst_sat", bus.o_sat, 0);
    chk("rst_cnt", bus.o_satCount, 0);

    bus.i_outReady = 1'b1;
    for (int i = 0; i < 4; i++) send_expect(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: hold the consumer off with a new triplet waiting.
    bus.i_outReady = 1'b0;
    drive(-5, 300, 7);
    bus.i_inValid = 1'b1;
    step();
    drive(50, -60, 70);
    step(); step(); step();
    chk("bp_valid", bus.o_outValid, 1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_inReady", bus.o_inReady, 0);
      chk("bp_r_stable", bus.o_r, -5);
      chk("bp_g_stable", bus.o_g, 127);
      chk("bp_b_stable", bus.o_b, 7);
      step();
    end
    bus.i_outReady = 1'b1;
    #1;
    chk("bp_inReady_comb", bus.o_inReady, 1);
    step();
    bus.i_inValid = 1'b0;
    chk("bp_next0", bus.o_outValid, 0);
    step();
    chk("bp_next1", bus.o_outValid, 0);
    step();
    chk("bp_next2", bus.o_outValid, 0);
    step();
    chk("bp_next_valid", bus.o_outValid, 1);
    chk("bp_next_r", bus.o_r, 50);
    chk("bp_next_g", bus.o_g, -60);
    chk("bp_next_b", bus.o_b, 70);
    step();

    // Back-to-back: 8 triplets with both sides always ready.
    for (int i = 0; i < 8; i++) begin
      data_r[i] = rnd_ch(); data_g[i] = rnd_ch(); data_b[i] = rnd_ch();
    end
    idx = 0; nout = 0;
    drive(data_r[0], data_g[0], data_b[0]);
    bus.i_inValid = 1'b1;
    for (int c = 0; c < 80 && nout < 8; c++) begin
      if (bus.o_outValid) begin times[nout] = c; nout++; end
      acc = bus.o_inReady && bus.i_inValid;
      step();
      if (acc) begin
        idx++;
        if (idx < 8) drive(data_r[idx], data_g[idx], data_b[idx]);
        else bus.i_inValid = 1'b0;
      end
    end
    chk("b2b_outputs", nout, 8);
    for (int i = 1; i < 8; i++) chk("b2b_spacing", times[i] - times[i-1], 4);
    step(); step();

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 600; c++) begin
      drive(rnd_ch(), rnd_ch(), rnd_ch());
      bus.i_inValid  = ($urandom_range(0, 2) != 0);
      bus.i_outReady = ($urandom_range(0, 3) != 0);
      bus.i_clrCount = ($urandom_range(0, 29) == 0);
      step();
    end
    bus.i_inValid = 1'b0; bus.i_outReady = 1'b1; bus.i_clrCount = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("drain_idle", bus.o_outValid, 0);
    chk("drain_empty", exp_q.size(), 0);

    // Counter wrap from 0xFFFF.
    force dut.cnt_q = 16'hFFFF;
    model_cnt = 32'hFFFF;
    #1;
    release dut.cnt_q;
    chk("preload_cnt", bus.o_satCount, 32'hFFFF);
    sv.cnt = 0;
    send_expect(sv, "wrap");

    // Clear in the same cycle as a saturating handshake.
    sv.cnt = 1;
    send_expect(sv, "pre_clr");
    drive(sv.r, sv.g, sv.b);
    bus.i_inValid = 1'b1;
    step();
    bus.i_inValid = 1'b0;
    step(); step(); step();
    chk("clr_valid", bus.o_outValid, 1);
    bus.i_clrCount = 1'b1;
    step();
    bus.i_clrCount = 1'b0;
    chk("clr_priority", bus.o_satCount, 0);

    // Reset while the S_G channel is being processed.
    drive(-1000, 1000, 0);
    bus.i_inValid = 1'b1;
    step();
    bus.i_inValid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_outValid", bus.o_outValid, 0);
    chk("midrst_inReady", bus.o_inReady, 1);
    chk("midrst_r", bus.o_r, 0);
    chk("midrst_g", bus.o_g, 0);
    chk("midrst_sat", bus.o_sat, 0);
    chk("midrst_cnt", bus.o_satCount, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("midrst_no_output", bus.o_outValid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
